eig_issuer: RTL and testbench
=============================

Name: eig_issuer

Overview:
- Request-side initiator for the eigenvalue core: buffers coefficient pairs (a0, a1) from the upstream estimator in a small FIFO.
- Issues one pair at a time to the core with a data_rdy pulse, tracks core_busy to detect completion, and captures kappa/inv_kappa/regime.
- Presents each result on a valid/ready stream to the watchdog decision logic, with a per-job timeout so a hung core cannot stall the pipeline.

Parameters:
- DEPTH, 4, request FIFO entries (power of two, >= 2)
- TIMEOUT, 1024, max cycles from issue to completion before the job is aborted
- W, 32, coefficient/result data width (signed, Q16.16)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- ena  in  1  global enable; when low, all state and counters hold; outputs keep their values
- req_valid  in  1  upstream pair valid
- req_ready  out  1  FIFO not full
- req_a0  in  W  coefficient a0 (signed)
- req_a1  in  W  coefficient a1 (signed)
- core_data_rdy  out  1  one-cycle start pulse to the core
- core_a0  out  W  registered a0 presented to the core
- core_a1  out  W  registered a1 presented to the core
- core_busy  in  1  core busy flag (high while computing)
- core_kappa  in  W  core result kappa
- core_inv_kappa  in  W  core result 1/kappa
- core_regime  in  3  core regime (100 over, 010 critical, 001 under)
- res_valid  out  1  result valid
- res_ready  in  1  downstream accepts result
- res_kappa  out  W  captured kappa
- res_inv_kappa  out  W  captured inv_kappa
- res_regime  out  3  captured regime; 000 on timeout
- res_timeout  out  1  result is a timeout abort
- fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy
- err_sticky  out  1  set on any timeout; cleared only by reset

Behaviour:
- Reset values: all outputs 0, except req_ready=1. FSM goes to IDLE, FIFO is empty, timeout counter is 0.
- FIFO:
  - Push on req_valid & req_ready & ena.
  - req_ready = (level != DEPTH).
  - Pop only in IDLE when issuing.
  - Simultaneous push and pop when full is not possible, because req_ready is low when full. When not full, level is unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, WAIT_ACK, WAIT_DONE, PRESENT.
  - IDLE: if FIFO is non-empty and res_valid=0, pop the head into core_a0/core_a1 and go to ISSUE.
  - ISSUE: core_data_rdy=1 for exactly this cycle; clear the timeout counter; go to WAIT_ACK.
  - WAIT_ACK: wait for core_busy=1, then go to WAIT_DONE. If core_busy stays 0 for 4 cycles, treat the job as complete (fast core) and capture results.
  - WAIT_DONE: on core_busy=0, capture core_kappa, core_inv_kappa and core_regime; set res_timeout=0; go to PRESENT.
  - PRESENT: res_valid=1; hold all res_* stable until res_ready. On the handshake, drop res_valid and return to IDLE (same-cycle reissue not allowed).
- Timeout:
  - The counter increments every enabled cycle in WAIT_ACK and WAIT_DONE.
  - When it reaches TIMEOUT-1: res_kappa=0, res_inv_kappa=0, res_regime=000, res_timeout=1, err_sticky=1; go to PRESENT.
  - A late core completion is ignored; the next job waits for core_busy=0 before ISSUE.
- Latency: first request into an empty FIFO gives core_data_rdy 2 cycles after the push cycle (FIFO write, IDLE pop, ISSUE).
- core_a0/core_a1 hold their values from the pop until the next pop.
- ena low mid-job: everything freezes, including the timeout counter. core_data_rdy is forced to 0 while ena is low; if ena drops in ISSUE, the pulse is re-emitted when ena returns.
- Async reset mid-job: the job is discarded and the FIFO is flushed; no result is emitted.

Decomposition:
- Shared package eig_pkg:
  - regime encodings REG_OVER=3'b100, REG_CRIT=3'b010, REG_UNDER=3'b001, REG_NONE=3'b000
  - issuer state enum
  - fixed-point constants (F=16)
- Sub-module: sync_fifo (parameterised W2=2*W, DEPTH) holding {a0,a1}; it is reusable elsewhere in the watchdog datapath.

Test Plan:
- Single job: push a0=0x00040000, a1=0x00010000; model core raises busy 1 cycle after core_data_rdy, drops it 20 cycles later with kappa=0x0001F000, regime=001 -> one core_data_rdy pulse with core_a0/core_a1 matching; res_valid with identical values, res_timeout=0.
- Back-to-back: push 5 pairs with DEPTH=4, core stalled -> req_ready low after 4 entries held in FIFO plus one in flight; jobs issue in order; results emitted in order with matching regimes.
- Backpressure: hold res_ready=0 for 50 cycles -> res_* stable, no new core_data_rdy until the res handshake completes.
- Timeout: core never drops busy, TIMEOUT=16 -> res_valid with res_timeout=1, res_regime=000, kappa=0, err_sticky=1, 16 cycles after issue; the next job waits for busy low.
- Enable gating: drop ena for 10 cycles during WAIT_DONE -> timeout counter and outputs frozen, no spurious pulse; completion proceeds after ena returns.
- Reset mid-job: assert rst_n=0 in WAIT_DONE with 3 entries queued -> all outputs 0, req_ready=1, fifo_level=0, no result after release.

Source files
------------

// File: rtl/eig_pkg.sv
// rtl/eig_pkg.sv - shared encodings and constants for the eigenvalue issuer
package eig_pkg;

    localparam int F = 16;

    localparam logic [2:0] REG_OVER  = 3'b100;
    localparam logic [2:0] REG_CRIT  = 3'b010;
    localparam logic [2:0] REG_UNDER = 3'b001;
    localparam logic [2:0] REG_NONE  = 3'b000;

    // A core that never raises busy is treated as done after this many cycles
    localparam int ACK_WAIT_CYCLES = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_ACK,
        ST_WAIT_DONE,
        ST_PRESENT
    } issuer_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy count and enable hold
module sync_fifo #(
    parameter int W2    = 64,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    input  logic          push,
    input  logic [W2-1:0] push_data,
    input  logic          pop,
    output logic [W2-1:0] pop_data,
    output logic [AW:0]   level,
    output logic          full,
    output logic          empty
);

    logic [W2-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full     = (level == (AW+1)'(DEPTH));
    assign empty    = (level == '0);
    assign do_push  = ena & push & ~full;
    assign do_pop   = ena & pop & ~empty;
    assign pop_data = mem[rd_ptr];

    // Pointers are AW bits wide, so wrap modulo DEPTH falls out of the width
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      level <= level + 1'b1;
            else if (!do_push && do_pop) level <= level - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/eig_issuer.sv
// rtl/eig_issuer.sv - queues coefficient pairs, issues them to the eigen core, presents results
module eig_issuer
    import eig_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024,
    parameter int W       = 32,
    localparam int LW     = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic signed [W-1:0] req_a0,
    input  logic signed [W-1:0] req_a1,
    output logic                core_data_rdy,
    output logic signed [W-1:0] core_a0,
    output logic signed [W-1:0] core_a1,
    input  logic                core_busy,
    input  logic signed [W-1:0] core_kappa,
    input  logic signed [W-1:0] core_inv_kappa,
    input  logic [2:0]          core_regime,
    output logic                res_valid,
    input  logic                res_ready,
    output logic signed [W-1:0] res_kappa,
    output logic signed [W-1:0] res_inv_kappa,
    output logic [2:0]          res_regime,
    output logic                res_timeout,
    output logic [LW-1:0]       fifo_level,
    output logic                err_sticky
);

    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] TC_LAST  = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] ACK_LAST = CW'(ACK_WAIT_CYCLES - 1);

    issuer_state_t state, state_nxt;
    logic [CW-1:0] tcnt;
    logic [CW-1:0] tcnt_nxt;
    logic [2*W-1:0] fifo_head;
    logic fifo_full;
    logic fifo_empty;
    logic pop;
    logic capture;
    logic abort;
    logic tcnt_clr;
    logic tcnt_inc;

    sync_fifo #(.W2(2*W), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .push      (req_valid),
        .push_data ({req_a0, req_a1}),
        .pop       (pop),
        .pop_data  (fifo_head),
        .level     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign req_ready     = ~fifo_full;
    assign core_data_rdy = (state == ST_ISSUE) & ena;
    assign tcnt_nxt      = tcnt + 1'b1;

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        capture   = 1'b0;
        abort     = 1'b0;
        tcnt_clr  = 1'b0;
        tcnt_inc  = 1'b0;
        case (state)
            // Waiting on core_busy low here keeps a late finisher from a timed-out job from overlapping the next issue
            ST_IDLE: begin
                if (!fifo_empty && !res_valid && !core_busy) begin
                    pop       = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                tcnt_clr  = 1'b1;
                state_nxt = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                tcnt_inc = 1'b1;
                if (tcnt_nxt == TC_LAST)  abort     = 1'b1;
                else if (core_busy)       state_nxt = ST_WAIT_DONE;
                else if (tcnt == ACK_LAST) capture  = 1'b1;
            end
            ST_WAIT_DONE: begin
                tcnt_inc = 1'b1;
                if (tcnt_nxt == TC_LAST) abort   = 1'b1;
                else if (!core_busy)     capture = 1'b1;
            end
            ST_PRESENT: begin
                if (res_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (capture || abort) state_nxt = ST_PRESENT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            tcnt          <= '0;
            core_a0       <= '0;
            core_a1       <= '0;
            res_valid     <= 1'b0;
            res_kappa     <= '0;
            res_inv_kappa <= '0;
            res_regime    <= REG_NONE;
            res_timeout   <= 1'b0;
            err_sticky    <= 1'b0;
        end else if (ena) begin
            state <= state_nxt;
            if (tcnt_clr)      tcnt <= '0;
            else if (tcnt_inc) tcnt <= tcnt_nxt;
            if (pop) begin
                core_a0 <= fifo_head[2*W-1:W];
                core_a1 <= fifo_head[W-1:0];
            end
            if (capture) begin
                res_kappa     <= core_kappa;
                res_inv_kappa <= core_inv_kappa;
                res_regime    <= core_regime;
                res_timeout   <= 1'b0;
            end else if (abort) begin
                res_kappa     <= '0;
                res_inv_kappa <= '0;
                res_regime    <= REG_NONE;
                res_timeout   <= 1'b1;
                err_sticky    <= 1'b1;
            end
            if (capture || abort)                   res_valid <= 1'b1;
            else if (state == ST_PRESENT && res_ready) res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_eig_issuer.sv
// tb/tb_eig_issuer.sv - scoreboard bench for eig_issuer with a behavioural core model
module tb_eig_issuer;

    localparam int W     = 32;
    localparam int DEPTH = 4;
    localparam int T     = 32;

    typedef struct { logic [31:0] a0; logic [31:0] a1; } iss_t;
    typedef struct { int len; logic [31:0] kappa; logic [31:0] inv; logic [2:0] rg; } job_t;
    typedef struct { logic [31:0] kappa; logic [31:0] inv; logic [2:0] rg; logic to; logic sticky; int lat; } res_t;

    logic clk, rst_n, ena, req_valid, req_ready;
    logic [W-1:0] req_a0, req_a1, core_a0, core_a1;
    logic core_data_rdy, core_busy;
    logic [W-1:0] core_kappa, core_inv_kappa;
    logic [2:0] core_regime;
    logic res_valid, res_ready, res_timeout, err_sticky;
    logic [W-1:0] res_kappa, res_inv_kappa;
    logic [2:0] res_regime;
    logic [2:0] fifo_level;

    iss_t exp_iss[$];
    job_t core_q[$];
    res_t exp_res[$];
    iss_t ei;
    job_t cj;
    res_t er;

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;
    int n_pulse = 0;
    int n_res = 0;
    int last_pulse = 0;
    int np, nr;
    logic sticky_model = 1'b0;
    logic prev_v, prev_r;
    logic [67:0] prev_b;

    eig_issuer #(.DEPTH(DEPTH), .TIMEOUT(T), .W(W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ena            (ena),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_a0         (req_a0),
        .req_a1         (req_a1),
        .core_data_rdy  (core_data_rdy),
        .core_a0        (core_a0),
        .core_a1        (core_a1),
        .core_busy      (core_busy),
        .core_kappa     (core_kappa),
        .core_inv_kappa (core_inv_kappa),
        .core_regime    (core_regime),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_kappa      (res_kappa),
        .res_inv_kappa  (res_inv_kappa),
        .res_regime     (res_regime),
        .res_timeout    (res_timeout),
        .fifo_level     (fifo_level),
        .err_sticky     (err_sticky)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    task automatic push_job(input logic [31:0] a0, input logic [31:0] a1, input int len,
                            input logic [31:0] k, input logic [31:0] inv, input logic [2:0] rg,
                            input logic to);
        iss_t i;
        job_t j;
        res_t r;
        int b;
        i.a0 = a0; i.a1 = a1;
        exp_iss.push_back(i);
        j.len = len; j.kappa = k; j.inv = inv; j.rg = rg;
        core_q.push_back(j);
        r.kappa = to ? 32'h0 : k;
        r.inv = to ? 32'h0 : inv;
        r.rg = to ? 3'b000 : rg;
        r.to = to;
        r.sticky = sticky_model;
        r.lat = to ? T : ((len == 0) ? 5 : len + 2);
        exp_res.push_back(r);
        @(negedge clk);
        req_valid = 1'b1; req_a0 = a0; req_a1 = a1;
        b = 0;
        while (!(req_ready && ena) && b < 300) begin
            @(negedge clk);
            b++;
        end
        if (b >= 300) chk("push_stall", 1, 0);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int b;
        b = 0;
        while (exp_res.size() > 0 && b < 600) begin
            @(negedge clk);
            b++;
        end
        chk("drain", exp_res.size(), 0);
        @(negedge clk);
    endtask

    task automatic wait_pulse(input int target);
        int b;
        b = 0;
        while (n_pulse < target && b < 200) begin
            @(negedge clk);
            b++;
        end
        chk("pulse_wait", (n_pulse >= target), 1);
    endtask

    // Core model: busy rises the cycle after the pulse and falls len cycles later with results
    initial begin
        core_busy = 1'b0; core_kappa = '0; core_inv_kappa = '0; core_regime = '0;
        forever begin
            @(negedge clk); #1;
            if (rst_n && core_data_rdy && core_q.size() > 0) begin
                cj = core_q.pop_front();
                @(negedge clk); #1;
                if (cj.len > 0) begin
                    core_busy = 1'b1;
                    repeat (cj.len) @(negedge clk);
                    #1;
                end
                core_busy = 1'b0;
                core_kappa = cj.kappa; core_inv_kappa = cj.inv; core_regime = cj.rg;
            end
        end
    end

    initial forever begin
        @(negedge clk); #1;
        if (rst_n && core_data_rdy) begin
            n_pulse++;
            last_pulse = cyc;
            chk("pulse_busy_low", core_busy, 0);
            if (exp_iss.size() == 0) chk("pulse_unexpected", 1, 0);
            else begin
                ei = exp_iss.pop_front();
                chk("core_a0", core_a0, ei.a0);
                chk("core_a1", core_a1, ei.a1);
            end
        end
    end

    initial begin
        prev_v = 1'b0; prev_r = 1'b1; prev_b = '0;
        forever begin
            @(negedge clk); #1;
            if (!rst_n) begin
                prev_v = 1'b0; prev_r = 1'b1;
            end else begin
                if (res_valid && !prev_v && exp_res.size() > 0)
                    chk("res_latency", cyc - last_pulse, exp_res[0].lat);
                if (res_valid && prev_v && !prev_r)
                    chk("res_stable", {res_kappa, res_inv_kappa, res_regime, res_timeout}, prev_b);
                if (res_valid && res_ready) begin
                    n_res++;
                    if (exp_res.size() == 0) chk("res_unexpected", 1, 0);
                    else begin
                        er = exp_res.pop_front();
                        chk("res_kappa", res_kappa, er.kappa);
                        chk("res_inv_kappa", res_inv_kappa, er.inv);
                        chk("res_regime", res_regime, er.rg);
                        chk("res_timeout", res_timeout, er.to);
                        chk("err_sticky", err_sticky, er.sticky);
                    end
                end
                prev_v = res_valid;
                prev_r = res_ready;
                prev_b = {res_kappa, res_inv_kappa, res_regime, res_timeout};
            end
        end
    end

    initial begin
        rst_n = 1'b0; ena = 1'b1; req_valid = 1'b0; req_a0 = '0; req_a1 = '0; res_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_level", fifo_level, 0);
        chk("rst_flags", {core_data_rdy, res_valid, res_timeout, err_sticky, res_regime}, 0);
        chk("rst_data", {core_a0, core_a1, res_kappa, res_inv_kappa}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        push_job(32'h00040000, 32'h00010000, 20, 32'h0001F000, 32'h00008421, 3'b001, 1'b0);
        @(negedge clk); #1 chk("lat_cycle0", core_data_rdy, 0);
        @(negedge clk); #1 chk("lat_cycle1", core_data_rdy, 1);
        wait_drain();

        push_job(32'h00020000, 32'h00008000, 25, 32'h00018000, 32'h0000AAAA, 3'b100, 1'b0);
        push_job(32'h00030000, 32'hFFFF0000,  3, 32'h00010000, 32'h00010000, 3'b010, 1'b0);
        push_job(32'h00050000, 32'h00000001,  0, 32'h00002000, 32'h00080000, 3'b001, 1'b0);
        push_job(32'hFFFE0000, 32'h00020000,  6, 32'h00030000, 32'h00005555, 3'b100, 1'b0);
        push_job(32'h7FFF0000, 32'h80000000,  2, 32'h00004000, 32'h00040000, 3'b001, 1'b0);
        @(negedge clk); #1;
        chk("b2b_level", fifo_level, 4);
        chk("b2b_ready", req_ready, 0);
        wait_drain();
        chk("b2b_ready_after", req_ready, 1);

        res_ready = 1'b0;
        push_job(32'h00011111, 32'h00022222, 4, 32'h00012345, 32'h0000DEAD, 3'b010, 1'b0);
        push_job(32'h00033333, 32'h00044444, 3, 32'h00054321, 32'h0000BEEF, 3'b100, 1'b0);
        begin
            int b;
            b = 0;
            while (!res_valid && b < 100) begin
                @(negedge clk); #1;
                b++;
            end
            chk("bp_valid_seen", res_valid, 1);
        end
        np = n_pulse;
        repeat (50) @(negedge clk);
        #1;
        chk("bp_no_issue", n_pulse, np);
        chk("bp_level", fifo_level, 1);
        chk("bp_valid_held", res_valid, 1);
        @(negedge clk);
        res_ready = 1'b1;
        wait_drain();
        chk("bp_resume", n_pulse, np + 1);

        sticky_model = 1'b1;
        push_job(32'h00066666, 32'h00077777, 60, 32'h0BADBAD0, 32'h0BADBAD0, 3'b100, 1'b1);
        push_job(32'h00088888, 32'h00099999, 3, 32'h00024000, 32'h00007000, 3'b010, 1'b0);
        wait_drain();
        chk("to_sticky_held", err_sticky, 1);

        np = n_pulse;
        push_job(32'h000AAAAA, 32'h000BBBBB, 35, 32'h00031000, 32'h00005400, 3'b001, 1'b0);
        wait_pulse(np + 1);
        repeat (10) @(negedge clk);
        ena = 1'b0;
        np = n_pulse;
        repeat (10) begin
            @(negedge clk); #1;
            chk("ena_no_pulse", core_data_rdy, 0);
        end
        chk("ena_pulse_count", n_pulse, np);
        chk("ena_no_result", res_valid, 0);
        @(negedge clk);
        ena = 1'b1;
        wait_drain();

        np = n_pulse;
        push_job(32'h00010000, 32'h00020000, 25, 32'h1, 32'h2, 3'b001, 1'b0);
        push_job(32'h00030000, 32'h00040000, 3, 32'h3, 32'h4, 3'b010, 1'b0);
        push_job(32'h00050000, 32'h00060000, 3, 32'h5, 32'h6, 3'b100, 1'b0);
        push_job(32'h00070000, 32'h00080000, 3, 32'h7, 32'h8, 3'b001, 1'b0);
        repeat (8) @(negedge clk);
        #1;
        chk("rst_pre_level", fifo_level, 3);
        chk("rst_pre_busy", core_busy, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rstm_req_ready", req_ready, 1);
        chk("rstm_level", fifo_level, 0);
        chk("rstm_flags", {core_data_rdy, res_valid, res_timeout, err_sticky, res_regime}, 0);
        chk("rstm_data", {core_a0, core_a1, res_kappa, res_inv_kappa}, 0);
        exp_res.delete();
        exp_iss.delete();
        core_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        np = n_pulse;
        nr = n_res;
        repeat (60) @(negedge clk);
        #1;
        chk("rst_no_issue", n_pulse, np);
        chk("rst_no_result", n_res, nr);
        chk("rst_level_after", fifo_level, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
